// File: rtl/note_tone_gen_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the tone generator.
package note_pkg;

    localparam int NUM_NOTES = 10;

    localparam int unsigned BASE_HZ [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Half period in clock cycles for a base frequency shifted up by oct octaves.
    // Only ever evaluated on constants, so it never becomes a runtime divider.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned hz,
                                                input int unsigned oct);
        int unsigned h;
        if (hz == 0) begin
            return 1;
        end
        h = (clk_hz / (2 * hz)) >> oct;
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Command handshake and audio outputs between the song sequencer and the tone generator.
interface note_tone_gen_if #(
    parameter int unsigned OCT_W = 2,
    parameter int unsigned DUR_W = 16
);

    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note;
    logic [OCT_W-1:0] octave;
    logic [DUR_W-1:0] duration;
    logic             stop;
    logic             tone_out;
    logic [12:0]      freq;
    logic             busy;
    logic             done;

    modport master (
        output note_valid, note, octave, duration, stop,
        input  note_ready, tone_out, freq, busy, done
    );

    modport slave (
        input  note_valid, note, octave, duration, stop,
        output note_ready, tone_out, freq, busy, done
    );

endinterface

// File: rtl/note_tone_gen_ms_tick_gen.sv
// Free-running millisecond strobe: one-cycle tick every DIV clocks, restartable by clear.
module ms_tick_gen #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap; clear holds the phase at zero so a new note starts a full ms.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note player: accepts one note command, plays it for its duration,
// optionally follows it with a silent gap, and reports the frequency being played.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OCT_W  = 2,
    parameter int unsigned DUR_W  = 16,
    parameter int unsigned GAP_MS = 0,
    parameter int unsigned HP_W   = 20
) (
    input  logic           clk,
    input  logic           reset,
    note_tone_gen_if.slave bus
);

    localparam int unsigned DIV     = CLK_HZ / 1000;
    localparam int unsigned NUM_OCT = 1 << OCT_W;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_GAP  = GAP;

    logic [1:0]       state;
    logic [HP_W-1:0]  half_len;
    logic [HP_W-1:0]  half_cnt;
    logic [DUR_W-1:0] ms_left;
    logic             is_tone;
    logic             tone_q;
    logic [12:0]      freq_q;
    logic             done_q;
    logic             accept;
    logic             ms_tick;
    logic             tick_clear;

    logic [HP_W-1:0]  half_tbl [16][NUM_OCT];
    logic [12:0]      freq_tbl [16][NUM_OCT];

    // Constant lookup tables for every note/octave pair; indices 10..15 are rests.
    for (genvar n = 0; n < 16; n++) begin : g_note
        for (genvar o = 0; o < int'(NUM_OCT); o++) begin : g_oct
            if (n < NUM_NOTES) begin : g_tone
                assign half_tbl[n][o] = HP_W'(half_period(CLK_HZ, BASE_HZ[n], o));
                assign freq_tbl[n][o] = 13'(BASE_HZ[n] << o);
            end else begin : g_rest
                assign half_tbl[n][o] = '0;
                assign freq_tbl[n][o] = '0;
            end
        end
    end

    assign accept     = bus.note_valid && (state == ST_IDLE);
    assign tick_clear = (state == ST_IDLE);

    ms_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (ms_tick)
    );

    assign bus.note_ready = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.tone_out   = tone_q;
    assign bus.freq       = freq_q;
    assign bus.done       = done_q;

    // Main sequencer: accept, toggle the square wave, count down ms, and handle stop/completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            half_len <= '0;
            half_cnt <= '0;
            ms_left  <= '0;
            is_tone  <= 1'b0;
            tone_q   <= 1'b0;
            freq_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        half_len <= half_tbl[bus.note][bus.octave];
                        half_cnt <= half_tbl[bus.note][bus.octave];
                        is_tone  <= (bus.note < 4'(NUM_NOTES));
                        if (bus.duration == '0) begin
                            tone_q <= 1'b0;
                            freq_q <= '0;
                            if (GAP_MS > 0) begin
                                state   <= ST_GAP;
                                ms_left <= DUR_W'(GAP_MS);
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            state   <= ST_PLAY;
                            ms_left <= bus.duration;
                            tone_q  <= (bus.note < 4'(NUM_NOTES));
                            freq_q  <= freq_tbl[bus.note][bus.octave];
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        tone_q <= 1'b0;
                        freq_q <= '0;
                    end else begin
                        if (is_tone) begin
                            if (half_cnt <= HP_W'(1)) begin
                                tone_q   <= ~tone_q;
                                half_cnt <= half_len;
                            end else begin
                                half_cnt <= half_cnt - HP_W'(1);
                            end
                        end
                        if (ms_tick) begin
                            if (ms_left == DUR_W'(1)) begin
                                tone_q <= 1'b0;
                                freq_q <= '0;
                                if (GAP_MS > 0) begin
                                    state   <= ST_GAP;
                                    ms_left <= DUR_W'(GAP_MS);
                                end else begin
                                    state  <= ST_IDLE;
                                    done_q <= 1'b1;
                                end
                            end else begin
                                ms_left <= ms_left - DUR_W'(1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (bus.stop) begin
                        state <= ST_IDLE;
                    end else if (ms_tick) begin
                        if (ms_left == DUR_W'(1)) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            ms_left <= ms_left - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tone_q <= 1'b0;
                    freq_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Testbench for note_tone_gen: two instances (no gap / 1 ms gap) driven with directed and
// random note commands, every cycle compared against an arithmetic model of the waveform.
module tb_note_tone_gen;

    localparam int CLK_HZ = 88000;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int OCT_W  = 2;
    localparam int DUR_W  = 16;
    localparam int HP_W   = 20;

    localparam int BASE_TABLE [10] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659};

    logic             clk = 1'b0;
    logic             reset;
    logic             validReq;
    logic             stopReq;
    logic [3:0]       cmdNote;
    logic [OCT_W-1:0] cmdOct;
    logic [DUR_W-1:0] cmdDur;
    int               sel;
    int               compared;
    int               mismatched;

    note_tone_gen_if #(.OCT_W(OCT_W), .DUR_W(DUR_W)) bus0 ();
    note_tone_gen_if #(.OCT_W(OCT_W), .DUR_W(DUR_W)) bus1 ();

    assign bus0.note_valid = validReq && (sel == 0);
    assign bus0.stop       = stopReq && (sel == 0);
    assign bus0.note       = cmdNote;
    assign bus0.octave     = cmdOct;
    assign bus0.duration   = cmdDur;

    assign bus1.note_valid = validReq && (sel == 1);
    assign bus1.stop       = stopReq && (sel == 1);
    assign bus1.note       = cmdNote;
    assign bus1.octave     = cmdOct;
    assign bus1.duration   = cmdDur;

    note_tone_gen #(.CLK_HZ(CLK_HZ), .OCT_W(OCT_W), .DUR_W(DUR_W), .GAP_MS(0), .HP_W(HP_W)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    note_tone_gen #(.CLK_HZ(CLK_HZ), .OCT_W(OCT_W), .DUR_W(DUR_W), .GAP_MS(1), .HP_W(HP_W)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    function automatic logic [16:0] observe();
        if (sel == 0) begin
            return {bus0.note_ready, bus0.busy, bus0.done, bus0.tone_out, bus0.freq};
        end
        return {bus1.note_ready, bus1.busy, bus1.done, bus1.tone_out, bus1.freq};
    endfunction

    function automatic logic [16:0] pack(input bit r, input bit b, input bit dn, input bit tn, input int f);
        return {r, b, dn, tn, 13'(f)};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] got, input logic [16:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got rdy/busy/done/tone/freq=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     tag, got[16], got[15], got[14], got[13], got[12:0],
                     exp[16], exp[15], exp[14], exp[13], exp[12:0]);
        end
    endtask

    // Called at the negedge of cycle t=1 after the accepting edge; checks every cycle up to
    // completion, or up to the cycle after an abort (kind 1 = stop, kind 2 = reset).
    task automatic runNote(input int n, input int o, input int d, input int abortKind, input int abortAt);
        int  base;
        int  half;
        int  f;
        int  playLen;
        int  total;
        bit  isTone;
        logic [16:0] exp;
        isTone  = (n < 10);
        base    = isTone ? BASE_TABLE[n] : 0;
        half    = isTone ? ((CLK_HZ / (2 * base)) >> o) : 1;
        if (half < 1) half = 1;
        f       = (base << o) % 8192;
        playLen = d * DIV;
        total   = playLen + ((sel == 1) ? DIV : 0);
        for (int t = 1; t <= total + 2; t++) begin
            if (abortKind != 0 && t == abortAt + 1) begin
                exp = pack(1, 0, 0, 0, 0);
            end else if (t <= playLen) begin
                exp = pack(0, 1, 0, isTone && (((t - 1) / half) % 2 == 0), f);
            end else if (t <= total) begin
                exp = pack(0, 1, 0, 0, 0);
            end else begin
                exp = pack(1, 0, 1, 0, 0);
            end
            checkOutput($sformatf("dut%0d n%0d o%0d d%0d t%0d", sel, n, o, d, t), observe(), exp);
            if (abortKind != 0 && t == abortAt + 1) begin
                stopReq = 1'b0;
                reset   = 1'b0;
                break;
            end
            if (abortKind == 0 && t == total + 1) begin
                break;
            end
            if (abortKind == 1 && t == abortAt) stopReq = 1'b1;
            if (abortKind == 2 && t == abortAt) reset = 1'b1;
            @(negedge clk);
        end
    endtask

    // Present one command from idle, optionally keep valid high with a second command during
    // play, then check the note cycle by cycle.
    task automatic applyStimulus(input int n, input int o, input int d, input int abortKind, input int abortAt,
                                 input bit hold, input int n2, input int o2, input int d2);
        @(negedge clk);
        checkOutput($sformatf("dut%0d idle before n%0d", sel, n), observe(), pack(1, 0, 0, 0, 0));
        cmdNote  = 4'(n);
        cmdOct   = OCT_W'(o);
        cmdDur   = DUR_W'(d);
        validReq = 1'b1;
        stopReq  = 1'($urandom_range(0, 1));
        @(negedge clk);
        stopReq = 1'b0;
        if (hold) begin
            cmdNote = 4'(n2);
            cmdOct  = OCT_W'(o2);
            cmdDur  = DUR_W'(d2);
        end else begin
            validReq = 1'b0;
        end
        runNote(n, o, d, abortKind, abortAt);
    endtask

    // Test sequence
    initial begin
        int n, o, d, total, kind, at;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        validReq   = 1'b0;
        stopReq    = 1'b0;
        cmdNote    = '0;
        cmdOct     = '0;
        cmdDur     = '0;
        sel        = 0;
        repeat (3) @(negedge clk);
        sel = 0;
        checkOutput("dut0 in reset", observe(), pack(1, 0, 0, 0, 0));
        sel = 1;
        checkOutput("dut1 in reset", observe(), pack(1, 0, 0, 0, 0));
        reset = 1'b0;
        @(negedge clk);
        sel = 0;
        checkOutput("dut0 after reset", observe(), pack(1, 0, 0, 0, 0));
        sel = 1;
        checkOutput("dut1 after reset", observe(), pack(1, 0, 0, 0, 0));

        sel = 0;
        $display("[TB] directed notes, no gap");
        applyStimulus(5, 0, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(5, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(9, 3, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(12, 2, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] stop with a held command");
        applyStimulus(5, 0, 5, 1, 50, 1, 7, 1, 1);
        @(negedge clk);
        validReq = 1'b0;
        runNote(7, 1, 1, 0, 0);

        sel = 1;
        $display("[TB] gap instance");
        applyStimulus(5, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3, 0, 1, 2, DIV + 44, 0, 0, 0, 0);
        applyStimulus(8, 2, 2, 1, 2 * DIV + 10, 0, 0, 0, 0);

        $display("[TB] random notes");
        for (int i = 0; i < 20; i++) begin
            sel   = int'($urandom_range(0, 1));
            n     = int'($urandom_range(0, 15));
            o     = int'($urandom_range(0, 3));
            d     = int'($urandom_range(0, 3));
            total = d * DIV + ((sel == 1) ? DIV : 0);
            kind  = 0;
            at    = 0;
            if (total > 0 && $urandom_range(0, 3) == 0) begin
                kind = 1;
                at   = int'($urandom_range(1, total));
            end
            applyStimulus(n, o, d, kind, at, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
